// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory responder for the MEM stage (IDLE -> WAIT -> RESP).
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic [1:0]  dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rd_word;
    logic            accept;
    logic            mem_we;
    logic [3:0]      wmask;
    logic [31:0]     wlanes;
    logic            unused_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction
`endif

    // funct3[1:0] selects size (00 byte, 01 half, 1x word); funct3[2] selects zero-extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign unused_addr = ^req_addr[31:AW+2];
    assign accept      = !reset && (state_q == S_IDLE) && req_valid;
    assign rd_word     = mem[idx_q];

    always_comb begin
        wmask  = 4'b1111;
        wlanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wmask  = 4'b0001 << req_addr[1:0];
                wlanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mem_we = accept && req_we && !misaligned(req_funct3, req_addr[1:0]);
`else
    assign mem_we = accept && req_we;
`endif

    // Stores commit at the acceptance edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[req_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        f3_d        = f3_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    idx_d   = req_addr[AW+1:2];
                    lane_d  = req_addr[1:0];
                    f3_d    = req_funct3;
                    we_d    = req_we;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'b0 : load_extract(f3_q, lane_q, rd_word);
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (misaligned(f3_q, lane_q)) begin
                        rsp_rdata_d = 32'b0;
                        err_d       = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            lane_q      <= 2'b00;
            f3_q        <= 3'b000;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign stall     = !reset && (((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT));
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-addressed reference memory, driver tasks, decoupled monitor.
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int MEMB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic [7:0]  mem_b [MEMB];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory is a flat byte array; an access touches 'size' bytes at the aligned base.
    function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] wdata, output logic [31:0] rdata,
                                         output logic e);
        int unsigned size;
        int unsigned a;
        int unsigned base;
        logic [31:0] val;
        size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        a     = addr;
        rdata = 32'b0;
        e     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00)) begin
            e = 1'b1;
            return;
        end
`endif
        base = (a - (a % size)) % MEMB;
        if (we) begin
            for (int i = 0; i < int'(size); i++) mem_b[base + i] = wdata[8*i +: 8];
        end else begin
            val = 32'b0;
            for (int i = 0; i < int'(size); i++) val = val | (32'(mem_b[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
            rdata = val;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold, input bit use_exp,
                          input logic [31:0] exp_rd);
        logic [31:0] m_rd;
        logic        m_err;
        model_access(we, f3, addr, wdata, m_rd, m_err);
        exp_q.push_back(use_exp ? exp_rd : m_rd);
        exp_err_q.push_back(m_err);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int c = 0; c <= LATENCY; c++) begin
            #1;
            check("stall_busy", 32'(stall), 32'd1);
            check("no_early_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        check("stall_in_resp", 32'(stall), 32'd0);
        check("rsp_timing", 32'(rsp_valid), 32'd1);
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_rsp: rsp_valid=1 with no outstanding request at %0t", $time);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
                    check("rsp_err", 32'(err), 32'(exp_err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_misw;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'b0;
        req_wdata  = 32'b0;
        idle(3);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b1, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b1, 32'hFFFFDEAD);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0000BEEF);
        do_req(1'b1, 3'b000, 32'h11, 32'h0000007F, 1'b0, 1'b1, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD7FEF);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_misw = 32'h0;
`else
        exp_misw = 32'hDEAD7FEF;
`endif
        do_req(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, 1'b1, exp_misw);

        // Reset during WAIT: the request must vanish without a response.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check("wait_state_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("stall_during_reset", 32'(stall), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < LATENCY + 3; c++) begin
            #1;
            check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD7FEF);

        // Request presented together with reset is only taken once reset drops.
        reset     = 1'b1;
        req_valid = 1'b1;
        #1;
        check("stall_req_in_reset", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0000DEAD);

        // Held req_valid through RESP: the next acceptance happens in the following IDLE cycle.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b1, 32'hDEAD7FEF);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 1'b1, 32'h0000007F);

        for (int w = 0; w < DEPTH; w++) begin
            do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, 1'b0, 32'h0);
        end
        for (int n = 0; n < 250; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   1'b0, 1'b0, 32'h0);
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined RV32I core. It accepts one load/store request at a time and performs RV32I byte, half and word access with sign/zero extension. While busy it drives `stall`, which deasserts `en` on the pipeline flops so that upstream state holds. It returns exactly one response pulse per accepted request.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array; must be a power of 2.
- `LATENCY`, default 2: number of WAIT cycles per access; minimum 1.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present; held stable by requester while `stall`=1.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I load/store funct3.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `stall`  out  1: freeze request to the pipeline flops.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  32: extended load data; 0 for stores.
- `err`  out  1: misaligned-access flag, valid with `rsp_valid`.

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE, counter=0, `rsp_valid`=0, `rsp_rdata`=0, `err`=0. Memory contents are not reset.
- `stall` = (IDLE && `req_valid`) || WAIT. It is combinational and is 0 in RESP and while `reset`=1.
- IDLE and `req_valid`: accept at the edge and go to WAIT with counter=LATENCY-1. A store commits to the array at this acceptance edge.
- WAIT: decrement the counter each edge. When counter==0, go to RESP at the next edge, register `rsp_valid`=1 and register `rsp_rdata` from the array sampled at that edge.
- RESP: `rsp_valid`=1 for this cycle only. `req_valid` is ignored because it is the retiring request. Next edge goes to IDLE.
- Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses alias.
- funct3 handling:
  - 000 = lb/sb, 001 = lh/sh, 010 = lw/sw, 100 = lbu, 101 = lhu.
  - 011, 110 and 111 are treated as word access.
  - Stores with 100 or 101 are treated as sb/sh.
- Byte lane is selected by `addr[1:0]`; half lane by `addr[1]`.
- lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- sb/sh write only the addressed lanes; other lanes are unchanged.
- Misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠0.

## Timing
- Request first seen in cycle 0 (IDLE).
- `stall`=1 in cycles 0..LATENCY, so LATENCY+1 cycles total.
- `rsp_valid`=1 in cycle LATENCY+1, and `stall`=0 in that cycle. The pipeline flops capture `rsp_rdata` at the end of cycle LATENCY+1.
- Back-to-back requests: the next request is accepted no earlier than cycle LATENCY+2. Throughput is one access per LATENCY+2 cycles.
- Reset mid-operation (WAIT or RESP):
  - Return to IDLE at that edge; no `rsp_valid` is issued.
  - `stall`=0 while `reset` is high.
  - An already-committed store remains in memory.
- `req_valid` asserted together with `reset`: the request is ignored. It is accepted in the first IDLE cycle after `reset` drops.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned access performs no write and returns `rsp_rdata`=0.
  - `err`=1 in the `rsp_valid` cycle; normal latency applies.
- Undefined:
  - Misaligned low address bits are ignored: half access uses `addr[1]` only, word access ignores `addr[1:0]`.
  - `err` is tied to 0.

## Test plan
- LATENCY=2, sw 0xDEADBEEF @0x10 → `stall`=1 in cycles 0–2, `rsp_valid`=1 in cycle 3 only with `rsp_rdata`=0. A following lw @0x10 → 0xDEADBEEF.
- After the store above, lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x0000007F @0x11, then lw @0x10 → 0xDEAD7FEF, proving the other lanes are unchanged.
- lw @0x12:
  - With `DMEM_MISALIGN_TRAP_EN`: `err`=1, `rsp_rdata`=0.
  - Without it: `err`=0, `rsp_rdata`=0xDEAD7FEF.
- Assert `reset` during the WAIT of lw @0x10 → no `rsp_valid` pulse; `stall`=0 while `reset` is high. A subsequent lw @0x10 → 0xDEAD7FEF.
- `req_valid` held through RESP → no second acceptance in RESP; a new request is accepted in the next IDLE cycle. Exactly one `rsp_valid` per accepted request.
